// File: rtl/cfg_reg_bank.sv
// Command-driven configuration register bank: shadow channel/baud registers,
// auto or explicit commit to the active outputs (held off by cfg_busy_i), and sticky error flags.
module cfg_reg_bank #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned RST_CHNL = 3,
    parameter int unsigned RST_BAUD = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic [NUM_CH*DW-1:0]     div_data_i,
    input  logic                     cfg_busy_i,
    input  logic [DW-1:0]            cmd_addr_i,
    input  logic [DW-1:0]            cmd_data_i,
    input  logic [1:0]               cmd_opt_i,
    output logic [DW-1:0]            cmd_rdata_o,
    output logic                     cmd_rvalid_o,
    output logic                     cmd_err_o,
    output logic [$clog2(NUM_CH)-1:0] con_bit_o,
    output logic [2:0]               uart_baud_o,
    output logic                     cfg_upd_o
);

    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_sh_chnl;
    logic [CH_W-1:0]   r_act_chnl;
    logic [2:0]        r_sh_baud;
    logic [2:0]        r_act_baud;
    logic              r_auto;
    logic              r_addr_err;
    logic              r_val_err;
    logic [DW-1:0]     r_rdata;
    logic              r_rvalid;
    logic              r_err;
    logic              r_upd;

    logic              w_wr;
    logic              w_rd;
    logic              w_a_chnl;
    logic              w_a_div;
    logic              w_a_baud;
    logic              w_a_ctrl;
    logic              w_a_stat;
    logic              w_a_bad;
    logic              w_chnl_ok;
    logic              w_wr_chnl;
    logic              w_wr_baud;
    logic              w_wr_ctrl;
    logic              w_wr_stat;
    logic              w_addr_err;
    logic              w_val_err;
    logic              w_req;
    logic [DW-1:0]     w_div_sel;
    logic [DW-1:0]     w_rd_mux;

    always_comb begin
        w_wr       = (cmd_opt_i == 2'b01);
        w_rd       = (cmd_opt_i == 2'b10);
        w_a_chnl   = (cmd_addr_i == DW'(0));
        w_a_div    = (cmd_addr_i == DW'(1));
        w_a_baud   = (cmd_addr_i == DW'(2));
        w_a_ctrl   = (cmd_addr_i == DW'(3));
        w_a_stat   = (cmd_addr_i == DW'(4));
        w_a_bad    = (cmd_addr_i > DW'(4));
        w_chnl_ok  = (cmd_data_i < DW'(NUM_CH));
        w_wr_chnl  = w_wr & w_a_chnl & w_chnl_ok;
        w_wr_baud  = w_wr & w_a_baud;
        w_wr_ctrl  = w_wr & w_a_ctrl;
        w_wr_stat  = w_wr & w_a_stat;
        w_val_err  = w_wr & w_a_chnl & ~w_chnl_ok;
        w_addr_err = ((w_wr | w_rd) & w_a_bad) | (w_wr & w_a_div);
        // AUTO is sampled before this edge's CTRL write takes effect
        w_req      = (r_auto & (w_wr_chnl | w_wr_baud)) | (w_wr_ctrl & cmd_data_i[0]);
    end

    always_comb begin
        w_div_sel = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (r_act_chnl == CH_W'(k)) begin
                w_div_sel = div_data_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_a_chnl) begin
            w_rd_mux = DW'(r_sh_chnl);
        end else if (w_a_div) begin
            w_rd_mux = w_div_sel;
        end else if (w_a_baud) begin
            w_rd_mux = DW'(r_sh_baud);
        end else if (w_a_ctrl) begin
            w_rd_mux = DW'({r_auto, 1'b0});
        end else if (w_a_stat) begin
            w_rd_mux = DW'({r_val_err, r_addr_err, r_state == ST_PEND});
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_chnl  <= CH_W'(RST_CHNL);
            r_sh_baud  <= 3'(RST_BAUD);
            r_auto     <= 1'b1;
            r_addr_err <= 1'b0;
            r_val_err  <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_err    <= w_addr_err | w_val_err;
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
            if (w_wr_chnl) begin
                r_sh_chnl <= cmd_data_i[CH_W-1:0];
            end
            if (w_wr_baud) begin
                r_sh_baud <= cmd_data_i[2:0];
            end
            if (w_wr_ctrl) begin
                r_auto <= cmd_data_i[1];
            end
            // set takes priority over a simultaneous write-1-to-clear
            r_addr_err <= w_addr_err | (r_addr_err & ~(w_wr_stat & cmd_data_i[1]));
            r_val_err  <= w_val_err  | (r_val_err  & ~(w_wr_stat & cmd_data_i[2]));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_act_chnl <= CH_W'(RST_CHNL);
            r_act_baud <= 3'(RST_BAUD);
            r_upd      <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!cfg_busy_i) begin
                        r_act_chnl <= r_sh_chnl;
                        r_act_baud <= r_sh_baud;
                        r_upd      <= 1'b1;
                        r_state    <= w_req ? ST_PEND : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_rdata_o  = r_rdata;
    assign cmd_rvalid_o = r_rvalid;
    assign cmd_err_o    = r_err;
    assign con_bit_o    = r_act_chnl;
    assign uart_baud_o  = r_act_baud;
    assign cfg_upd_o    = r_upd;

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: expected read data queued at issue and
// compared when rvalid appears; output/pulse checks after each step.
module tb_cfg_reg_bank;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_n;
    logic [NUM_CH*DW-1:0] div_data_i;
    logic                 cfg_busy_i;
    logic [DW-1:0]        cmd_addr_i;
    logic [DW-1:0]        cmd_data_i;
    logic [1:0]           cmd_opt_i;
    logic [DW-1:0]        cmd_rdata_o;
    logic                 cmd_rvalid_o;
    logic                 cmd_err_o;
    logic [1:0]           con_bit_o;
    logic [2:0]           uart_baud_o;
    logic                 cfg_upd_o;

    int errors = 0;
    int checks = 0;
    int upd_cnt = 0;
    int rv_cnt = 0;
    int rd_cnt = 0;
    int mark;
    logic [DW-1:0] sb[$];

    cfg_reg_bank #(
        .NUM_CH  (NUM_CH),
        .DW      (DW),
        .RST_CHNL(3),
        .RST_BAUD(5)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .div_data_i  (div_data_i),
        .cfg_busy_i  (cfg_busy_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_opt_i   (cmd_opt_i),
        .cmd_rdata_o (cmd_rdata_o),
        .cmd_rvalid_o(cmd_rvalid_o),
        .cmd_err_o   (cmd_err_o),
        .con_bit_o   (con_bit_o),
        .uart_baud_o (uart_baud_o),
        .cfg_upd_o   (cfg_upd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and pulse counter, sampled 1ns after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (cfg_upd_o === 1'b1) upd_cnt++;
        if (cmd_rvalid_o === 1'b1) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'(cmd_rvalid_o), 32'h0);
            end else begin
                check("rdata", 32'(cmd_rdata_o), 32'(sb.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic do_cmd(input logic [1:0] opt, input logic [7:0] addr, input logic [7:0] data);
        cmd_opt_i  = opt;
        cmd_addr_i = addr;
        cmd_data_i = data;
        cyc();
        cmd_opt_i = 2'b00;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        do_cmd(2'b01, addr, data);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        sb.push_back(exp);
        rd_cnt++;
        do_cmd(2'b10, addr, 8'h00);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        cfg_busy_i = 1'b0;
        cmd_opt_i  = 2'b00;
        cmd_addr_i = '0;
        cmd_data_i = '0;
        div_data_i = 32'h4D3C2B1A;
        repeat (3) cyc();
        check("rst_con", 32'(con_bit_o), 32'd3);
        check("rst_baud", 32'(uart_baud_o), 32'd5);
        check("rst_rvalid", 32'(cmd_rvalid_o), 32'd0);
        check("rst_err", 32'(cmd_err_o), 32'd0);
        check("rst_upd", 32'(cfg_upd_o), 32'd0);
        check("rst_rdata", 32'(cmd_rdata_o), 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        rd(8'h03, 8'h02);
        rd(8'h04, 8'h00);
        rd(8'h00, 8'h03);
        rd(8'h02, 8'h05);
        check("post_rst_upd_cnt", 32'(upd_cnt), 32'd0);

        // Auto commit
        mark = upd_cnt;
        wr(8'h00, 8'h01);
        check("auto_con_before_apply", 32'(con_bit_o), 32'd3);
        check("auto_upd_before_apply", 32'(cfg_upd_o), 32'd0);
        rd(8'h04, 8'h01);
        check("auto_con_applied", 32'(con_bit_o), 32'd1);
        check("auto_upd_pulse", 32'(cfg_upd_o), 32'd1);
        rd(8'h01, 8'h2B);
        check("auto_upd_drop", 32'(cfg_upd_o), 32'd0);
        rd(8'h04, 8'h00);
        check("auto_upd_once", 32'(upd_cnt - mark), 32'd1);

        // Busy deferral
        mark = upd_cnt;
        cfg_busy_i = 1'b1;
        wr(8'h02, 8'h02);
        wr(8'h02, 8'h07);
        rd(8'h04, 8'h01);
        rd(8'h02, 8'h07);
        repeat (3) cyc();
        check("busy_baud_held", 32'(uart_baud_o), 32'd5);
        check("busy_no_upd", 32'(upd_cnt - mark), 32'd0);
        cfg_busy_i = 1'b0;
        cyc();
        check("busy_baud_applied", 32'(uart_baud_o), 32'd7);
        check("busy_upd_pulse", 32'(cfg_upd_o), 32'd1);
        repeat (2) cyc();
        check("busy_single_apply", 32'(upd_cnt - mark), 32'd1);
        check("busy_con_kept", 32'(con_bit_o), 32'd1);

        // Manual commit
        mark = upd_cnt;
        wr(8'h03, 8'h00);
        wr(8'h00, 8'h02);
        cyc();
        check("man_con_held", 32'(con_bit_o), 32'd1);
        rd(8'h04, 8'h00);
        rd(8'h03, 8'h00);
        rd(8'h00, 8'h02);
        check("man_no_upd", 32'(upd_cnt - mark), 32'd0);
        wr(8'h03, 8'h01);
        cyc();
        check("man_con_applied", 32'(con_bit_o), 32'd2);
        check("man_upd_pulse", 32'(cfg_upd_o), 32'd1);
        rd(8'h03, 8'h00);

        // Errors
        wr(8'h00, 8'h04);
        check("val_err_pulse", 32'(cmd_err_o), 32'd1);
        cyc();
        check("val_err_one_cycle", 32'(cmd_err_o), 32'd0);
        rd(8'h04, 8'h04);
        check("rd_stat_no_err", 32'(cmd_err_o), 32'd0);
        rd(8'h00, 8'h02);
        rd(8'h09, 8'h00);
        check("addr_err_pulse", 32'(cmd_err_o), 32'd1);
        cyc();
        check("rvalid_one_cycle", 32'(cmd_rvalid_o), 32'd0);
        rd(8'h04, 8'h06);
        wr(8'h04, 8'h06);
        rd(8'h04, 8'h00);
        wr(8'h01, 8'h55);
        check("ro_write_err", 32'(cmd_err_o), 32'd1);
        rd(8'h04, 8'h02);
        wr(8'h04, 8'h02);
        rd(8'h04, 8'h00);
        check("err_con_kept", 32'(con_bit_o), 32'd2);

        // Commit request on the apply edge forces a second apply
        wr(8'h03, 8'h02);
        mark = upd_cnt;
        wr(8'h00, 8'h00);
        wr(8'h00, 8'h01);
        check("back2back_first_apply", 32'(con_bit_o), 32'd0);
        cyc();
        check("back2back_second_apply", 32'(con_bit_o), 32'd1);
        check("back2back_upd", 32'(cfg_upd_o), 32'd1);
        cyc();
        check("back2back_upd_cnt", 32'(upd_cnt - mark), 32'd2);
        rd(8'h04, 8'h00);

        // Reset in the middle of a pending commit
        cfg_busy_i = 1'b1;
        wr(8'h00, 8'h00);
        rd(8'h04, 8'h01);
        rst_n = 1'b0;
        #1;
        check("async_rst_con", 32'(con_bit_o), 32'd3);
        check("async_rst_baud", 32'(uart_baud_o), 32'd5);
        #2;
        rst_n = 1'b1;
        mark = upd_cnt;
        cfg_busy_i = 1'b0;
        repeat (3) cyc();
        check("rstpend_con", 32'(con_bit_o), 32'd3);
        check("rstpend_no_upd", 32'(upd_cnt - mark), 32'd0);
        rd(8'h04, 8'h00);
        rd(8'h03, 8'h02);
        rd(8'h01, 8'h4D);
        repeat (2) cyc();

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("rvalid_count", 32'(rv_cnt), 32'(rd_cnt));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfg_reg_bank.md
# cfg_reg_bank

Parametrised command-driven configuration register bank that replaces the fixed two-register controller in the clock-divider subsystem. It holds a channel select and a UART baud code in shadow registers, and applies them to the active outputs on commit. Commit is either automatic or explicit, and is deferred while the downstream divider reports busy. It also reads back the selected channel's divide factor and keeps sticky error/status flags.

## Interface
- NUM_CH, 4: number of divider channels (2..16); CH_W = clog2(NUM_CH) is a derived localparam.
- DW, 8: command address/data width and per-channel divide-factor width.
- RST_CHNL, 3: reset value of channel select (must be < NUM_CH).
- RST_BAUD, 5: reset value of the 3-bit baud code.
- clk_i  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- div_data_i  in  NUM_CH*DW  packed divide factors; channel k occupies bits [k*DW +: DW].
- cfg_busy_i  in  1  downstream busy; while high, commits are held pending.
- cmd_addr_i  in  DW  register address.
- cmd_data_i  in  DW  write data.
- cmd_opt_i  in  2  2'b01 WRITE, 2'b10 READ; 2'b00 and 2'b11 are idle.
- cmd_rdata_o  out  DW  read data.
- cmd_rvalid_o  out  1  one-cycle pulse when cmd_rdata_o is updated.
- cmd_err_o  out  1  one-cycle pulse on an illegal access.
- con_bit_o  out  CH_W  active channel select.
- uart_baud_o  out  3  active baud code.
- cfg_upd_o  out  1  one-cycle pulse when the active values change.

## Operation
- Address map (zero-extended to DW):
  - 0x00 CHNL_SEL, RW: shadow select, CH_W bits.
  - 0x01 DIV_FAC, RO: div_data_i slice selected by the *active* channel.
  - 0x02 UART_BAUD, RW: shadow baud, bits [2:0].
  - 0x03 CTRL, RW: bit0 COMMIT (write-1, reads 0); bit1 AUTO (reset 1).
  - 0x04 STATUS: bit0 PEND (RO); bit1 ADDR_ERR, W1C; bit2 VAL_ERR, W1C.
- Illegal accesses. Each one pulses cmd_err_o and changes no register.
  - Any access to an address > 0x04 sets ADDR_ERR; a read of such an address returns 0 with rvalid.
  - Writing 0x01 sets ADDR_ERR.
  - Writing CHNL_SEL with a value ≥ NUM_CH sets VAL_ERR.
- Commit state machine, states IDLE and PEND. PEND is visible as STATUS.PEND.
  - IDLE→PEND on a legal write to CHNL_SEL/UART_BAUD when AUTO=1, or on a CTRL write with bit0=1.
  - PEND→IDLE on the first clock edge with cfg_busy_i=0. At that edge the shadow values are copied to active and cfg_upd_o is asserted for the following cycle.
  - Further writes while in PEND update the shadow registers only. The value applied is the shadow value at the apply edge.
- With AUTO=0, shadow writes never commit until COMMIT is written.
- Reset values:
  - shadow and active select = RST_CHNL; shadow and active baud = RST_BAUD; AUTO=1.
  - Error flags 0; state IDLE.
  - cmd_rdata_o=0, cmd_rvalid_o=0, cmd_err_o=0, cfg_upd_o=0.
  - con_bit_o=RST_CHNL, uart_baud_o=RST_BAUD.

## Timing
- All commands are sampled at a rising edge; there is no backpressure and a command may arrive every cycle.
- Read sampled at edge N: cmd_rdata_o and cmd_rvalid_o update at N. cmd_rdata_o holds until the next read; rvalid is high for exactly one cycle.
- Write sampled at edge N: the shadow register updates at N and PEND is visible at N.
- Apply happens at the earliest edge N+1 if cfg_busy_i=0 at N+1. con_bit_o, uart_baud_o and cfg_upd_o update at the apply edge.
- Reading CHNL_SEL/UART_BAUD returns the shadow values. Reading DIV_FAC uses the active select as of the sampling edge.
- W1C on the same edge as a new error of the same type: set wins.
- Commit request arriving on the same edge as an apply: the request leaves the FSM in PEND, so a second apply follows.
- Reset asserted mid-PEND: the pending commit is discarded and all registers return to reset values asynchronously.

## Test plan
- Reset: rst_n low, then high → con_bit_o=3, uart_baud_o=5, read 0x03 returns 0x02, read 0x04 returns 0x00, no pulses.
- Auto commit: write 0x00=0x01 with busy=0 → PEND for 1 cycle, con_bit_o=1 one edge later, cfg_upd_o pulses once; read 0x01 returns div_data_i channel-1 slice.
- Busy deferral: hold cfg_busy_i=1, write 0x02=0x02 then 0x02=0x07, release busy → a single apply with uart_baud_o=7 on the first non-busy edge.
- Manual commit: write 0x03=0x00, write 0x00=0x02 → con_bit_o unchanged and PEND=0; then write 0x03=0x01 → con_bit_o=2 and cfg_upd_o pulses.
- Errors: write 0x00=0x04 (NUM_CH=4) → cmd_err_o pulse, STATUS=0x04. Read 0x09 → rdata=0, rvalid=1, STATUS=0x06. Write 0x04=0x06 → STATUS=0x00.
- Reset mid-PEND: busy=1, write 0x00=0x00, pulse rst_n → con_bit_o=3 and no cfg_upd_o after busy drops.
